// File: rtl/note_mixer_pwm.sv
// Seven-voice audio output stage: per-voice attack/release envelopes, a summing
// mixer and a frame-latched single-bit PWM driver for the board's audio pin.
module note_mixer_pwm #(
  parameter int NUM_VOICES = 7,
  parameter int ENV_DIV    = 200000,
  parameter int PWM_BITS   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_VOICES-1:0] tone_in,
  input  logic [NUM_VOICES-1:0] key_in,
  input  logic                  mute,
  output logic                  pwm_out,
  output logic [PWM_BITS-1:0]   sample_out,
  output logic                  frame_strobe,
  output logic [2:0]            active_voices
);

  localparam int PRE_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam int MIX_W = $clog2(NUM_VOICES * 15 + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(ENV_DIV - 1);

  logic [PRE_W-1:0]    presc;
  logic                env_tick;
  logic [3:0]          level [NUM_VOICES];
  logic [MIX_W-1:0]    mix_next;
  logic [MIX_W-1:0]    mix_reg;
  logic [2:0]          active_next;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_reg;

  assign env_tick = (presc == PRE_LAST);

  always_ff @(posedge clock) begin
    if (reset)
      presc <= '0;
    else if (env_tick)
      presc <= '0;
    else
      presc <= presc + PRE_W'(1);
  end

  // Levels move one step per tick toward 15 (key held) or 0 (key released).
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++)
        level[i] <= 4'd0;
    end else if (env_tick) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (key_in[i] && (level[i] != 4'd15))
          level[i] <= level[i] + 4'd1;
        else if (!key_in[i] && (level[i] != 4'd0))
          level[i] <= level[i] - 4'd1;
      end
    end
  end

  always_comb begin
    mix_next    = '0;
    active_next = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (tone_in[i])
        mix_next = mix_next + MIX_W'(level[i]);
      if (level[i] != 4'd0)
        active_next = active_next + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mix_reg       <= '0;
      active_voices <= '0;
    end else begin
      mix_reg       <= mix_next;
      active_voices <= active_next;
    end
  end

  assign frame_strobe = &pwm_cnt;

  // Duty only changes on the last cycle of a frame, so every frame is whole.
  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_cnt  <= '0;
      duty_reg <= '0;
      pwm_out  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      pwm_out <= (pwm_cnt < duty_reg);
      if (frame_strobe)
        duty_reg <= mute ? '0 : PWM_BITS'(mix_reg);
    end
  end

  assign sample_out = duty_reg;

endmodule

// File: doc/note_mixer_pwm.md
# note_mixer_pwm

Audio output stage downstream of the seven per-note Frequency_Generator square-wave outputs. Applies a per-voice attack/release envelope gated by the key bits, sums the enveloped voices into one amplitude sample, and drives a single-bit PWM output for the board's audio pin. One sample is latched per PWM frame, so duty changes are glitch-free.

## Interface
Parameters:
- NUM_VOICES, 7, number of note voices (bit i of tone_in/key_in is voice i)
- ENV_DIV, 200000, clock cycles per envelope tick; minimum 2
- PWM_BITS, 8, PWM counter width; frame length 2^PWM_BITS cycles

Ports:
- clock  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- tone_in  in  NUM_VOICES  square waves from the Frequency_Generators (same clock domain)
- key_in  in  NUM_VOICES  key-held bits (the key register bits 6:0)
- mute  in  1  forces duty 0 from the next frame boundary
- pwm_out  out  1  registered PWM audio output
- sample_out  out  PWM_BITS  duty value currently being played
- frame_strobe  out  1  one-cycle pulse on the cycle the duty is latched
- active_voices  out  3  count of voices with envelope level > 0

## Operation
- Envelope prescaler: counter 0..ENV_DIV-1, wraps to 0; env_tick asserts internally on the cycle count == ENV_DIV-1.
- Per-voice level: 4-bit unsigned, 0..15. On env_tick only: key_in[i]=1 and level<15 -> level+1; key_in[i]=0 and level>0 -> level-1; otherwise hold. Saturates at 15 and at 0, no wrap. key_in is sampled only on tick cycles; toggles between ticks are ignored.
- Mixer: mix_reg <= sum over i of (tone_in[i] ? level[i] : 0), registered every cycle. The maximum is 7*15 = 105, which fits in 7 bits. Zero-extend to PWM_BITS.
- PWM counter pwm_cnt: free-running 0..2^PWM_BITS-1, wraps to 0.
- Frame latch: on the cycle pwm_cnt == all-ones, duty_reg <= mute ? 0 : mix_reg and frame_strobe = 1. duty_reg and sample_out are equal at all times.
- pwm_out <= (pwm_cnt < duty_reg), registered. Duty D gives exactly D high cycles per frame. D=0 keeps pwm_out permanently low. 100% duty is unreachable with the default widths.
- active_voices: registered popcount of (level != 0), range 0..7.

## Timing
- Reset values: pwm_out=0, sample_out=0, frame_strobe=0, active_voices=0. All levels, prescaler, pwm_cnt, mix_reg and duty_reg are 0.
- Reset mid-operation clears everything on that edge; outputs read 0 on the following cycle.
- First env_tick after reset deassertion occurs ENV_DIV cycles later. Full attack 0->15 takes 15 ticks (15*ENV_DIV cycles); full release takes the same.
- Latency from tone_in/level to mix_reg: 1 cycle. From mix_reg to duty: up to 2^PWM_BITS cycles (next frame boundary). From duty to pwm_out: 1 cycle.
- First frame_strobe occurs 2^PWM_BITS-1 cycles after reset deassertion. Strobes then recur every 2^PWM_BITS cycles.
- Mute asserted or deasserted mid-frame takes effect only at the next latch; the current frame completes unchanged.
- env_tick coinciding with the frame latch: the latch uses mix_reg from before the level update.
- A key released during attack begins decaying from its current level at the next tick; there is no jump.

## Test plan
- ENV_DIV=4, key_in=7'h01, tone_in=7'h01 held from reset release -> level0 increments every 4 cycles and reaches 15 at cycle 60. The first latch after that gives sample_out=15, and pwm_out is high 15 cycles of each 256-cycle frame. active_voices=1.
- key_in=7'h7F, tone_in=7'h7F, all levels at 15 -> sample_out=105 (8'h69), pwm_out high 105/256 cycles, active_voices=7.
- From the all-15 state, key_in=0 -> levels decrement once per tick, reaching 0 after 15 ticks. sample_out then reads 0 at the next latch, pwm_out stays low, active_voices=0.
- Levels at 15, tone_in toggling 7'h01/7'h00 every cycle -> mix_reg alternates 15/0. The latched duty is the mix_reg value on the all-ones cycle; check against the model.
- Mute asserted at pwm_cnt=10 with duty 105 -> the current frame still outputs 105 high cycles, the next frame_strobe latches 0, and pwm_out stays low afterward.
- reset pulsed for 1 cycle with levels at 15 and pwm_out high -> next cycle all outputs 0. The first frame_strobe follows 255 cycles after reset deassertion, and levels restart from 0.
